irq_arbiter: RTL



---
 rtl/irq_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/irq_arbiter.sv
// External interrupt arbiter: per-source gateways, priority/threshold
// arbitration and a claim/complete register port in front of the CSR file.
module irq_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               cfg_ren,
  input  logic               cfg_wen,
  input  logic [5:0]         cfg_addr,
  input  logic [31:0]        cfg_wd,
  output logic [31:0]        cfg_rd,
  output logic               external_interrupt,
  output logic [4:0]         irq_id
);

  localparam logic [5:0] ADDR_ENABLE    = 6'h00;
  localparam logic [5:0] ADDR_THRESHOLD = 6'h01;
  localparam logic [5:0] ADDR_PENDING   = 6'h02;
  localparam logic [5:0] ADDR_CLAIM     = 6'h03;
  localparam logic [5:0] ADDR_PRIO_BASE = 6'h20;

  typedef enum logic [1:0] {IDLE, PENDING, CLAIMED} gw_state_t;

  gw_state_t          state      [NUM_SRC];
  gw_state_t          state_next [NUM_SRC];
  logic [PRIO_W-1:0]  prio       [NUM_SRC];
  logic [NUM_SRC-1:0] enable;
  logic [PRIO_W-1:0]  threshold;
  logic [NUM_SRC-1:0] pending;
  logic [4:0]         best_id;
  logic [PRIO_W-1:0]  best_prio;
  logic               claim;
  logic               complete;
  logic [31:0]        rd_data;
  logic               unused_wd;

  assign claim     = cfg_ren && (cfg_addr == ADDR_CLAIM);
  assign complete  = cfg_wen && (cfg_addr == ADDR_CLAIM);
  assign unused_wd = ^cfg_wd;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      pending[i] = (state[i] == PENDING);
    end
  end

  // Scanning from the top ID down with >= leaves the lowest ID on ties.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i] && enable[i] && (prio[i] != '0) && (prio[i] >= best_prio)) begin
        best_id   = 5'(i + 1);
        best_prio = prio[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      state_next[i] = state[i];
      case (state[i])
        IDLE:    if (src_irq[i]) state_next[i] = PENDING;
        PENDING: if (claim && (best_id == 5'(i + 1))) state_next[i] = CLAIMED;
        CLAIMED: if (complete && (cfg_wd[4:0] == 5'(i + 1))) state_next[i] = IDLE;
        default: state_next[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (reset) state[i] <= IDLE;
      else       state[i] <= state_next[i];
    end
  end

  always_comb begin
    rd_data = '0;
    case (cfg_addr)
      ADDR_ENABLE:    rd_data[NUM_SRC-1:0] = enable;
      ADDR_THRESHOLD: rd_data[PRIO_W-1:0]  = threshold;
      ADDR_PENDING:   rd_data[NUM_SRC-1:0] = pending;
      ADDR_CLAIM:     rd_data[4:0]         = best_id;
      default: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (cfg_addr == ADDR_PRIO_BASE + 6'(i)) rd_data[PRIO_W-1:0] = prio[i];
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enable    <= '0;
      threshold <= '0;
      for (int i = 0; i < NUM_SRC; i++) prio[i] <= '0;
    end else if (cfg_wen) begin
      case (cfg_addr)
        ADDR_ENABLE:    enable    <= cfg_wd[NUM_SRC-1:0];
        ADDR_THRESHOLD: threshold <= cfg_wd[PRIO_W-1:0];
        default: begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (cfg_addr == ADDR_PRIO_BASE + 6'(i)) prio[i] <= cfg_wd[PRIO_W-1:0];
          end
        end
      endcase
    end
  end

  // Read data is captured from pre-write values and held until the next read.
  always_ff @(posedge clock) begin
    if (reset) begin
      cfg_rd             <= '0;
      external_interrupt <= 1'b0;
      irq_id             <= '0;
    end else begin
      external_interrupt <= (best_prio > threshold);
      irq_id             <= best_id;
      if (cfg_ren) cfg_rd <= rd_data;
    end
  end

endmodule
